// File: rtl/mmio_motion_ctrl.sv
// Memory-mapped motion-control registers: axis readback, status, set/clear direction enables, run FSM.
// Optional watchdog: define WATCHDOG_EN.
module mmio_motion_ctrl #(
    parameter int ADDR_W      = 15,
    parameter int DATA_W      = 16,
    parameter int NUM_AXES    = 3,
    parameter int BASE_ADDR   = 20000,
    parameter int WDOG_CYCLES = 50000000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start_n,
    input  logic                         times_up,
    input  logic [ADDR_W-1:0]            addr,
    input  logic                         we,
    input  logic [DATA_W-1:0]            din,
    input  logic [NUM_AXES*DATA_W-1:0]   axis_pos,
    input  logic [DATA_W-1:0]            ram_dout,
    output logic [DATA_W-1:0]            mem_dout,
    output logic [2*NUM_AXES:0]          move_en,
    output logic                         run
);

    localparam int NB = 2 * NUM_AXES;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_STOP = 2'd2;
    localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] OFF_STATUS = ADDR_W'(NUM_AXES);
    localparam logic [ADDR_W-1:0] OFF_CTRL   = ADDR_W'(NUM_AXES + 1);

    logic              r_start_s1, r_start_s2, r_start_s3;
    logic              r_tu_s1, r_tu_s2;
    logic [1:0]        r_state, w_state_nxt;
    logic [NB-1:0]     r_dir, w_dir_nxt, w_dir_or, w_set_dir;
    logic              r_fault, w_fault_nxt;
    logic [ADDR_W-1:0] w_off;
    logic              w_hit, w_ctrl_wr, w_abort, w_start_ev, w_stop_ev, w_wdog_to;
    logic [DATA_W-1:0] w_status;
    logic              w_unused;

    assign w_off      = addr - BASE;
    assign w_hit      = (addr >= BASE) && (w_off <= OFF_CTRL);
    assign w_ctrl_wr  = we && w_hit && (w_off == OFF_CTRL);
    assign w_abort    = w_ctrl_wr && din[15] && din[14];
    // Stage 3 only remembers the previous synchronized level for falling-edge detection.
    assign w_start_ev = r_start_s3 && !r_start_s2;
    assign w_stop_ev  = r_tu_s2;

    // NOTE: non-blocking assignments make every flop sample the pre-edge value, which is what
    // turns this chain into a proper shift register rather than one collapsed stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_start_s1 <= 1'b1;
            r_start_s2 <= 1'b1;
            r_start_s3 <= 1'b1;
            r_tu_s1    <= 1'b0;
            r_tu_s2    <= 1'b0;
        end else begin
            r_start_s1 <= start_n;
            r_start_s2 <= r_start_s1;
            r_start_s3 <= r_start_s2;
            r_tu_s1    <= times_up;
            r_tu_s2    <= r_tu_s1;
        end
    end

`ifdef WATCHDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);
    logic [WD_W-1:0] r_wdog;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_wdog <= '0;
        else if (r_state != ST_RUN || w_ctrl_wr)
            r_wdog <= '0;
        else
            r_wdog <= r_wdog + WD_W'(1);
    end

    assign w_wdog_to = (r_state == ST_RUN) && !w_ctrl_wr && (r_wdog == WD_W'(WDOG_CYCLES - 1));
    assign w_unused  = &{1'b0, din};
`else
    assign w_wdog_to = 1'b0;
    assign w_unused  = &{1'b0, din, (WDOG_CYCLES > 0)};
`endif

    // An axis that ends up with both directions requested is disabled entirely.
    assign w_dir_or = r_dir | din[NB-1:0];
    always_comb begin
        w_set_dir = w_dir_or;
        for (int i = 0; i < NUM_AXES; i++)
            if (w_dir_or[2*i] && w_dir_or[2*i+1])
                w_set_dir[2*i +: 2] = 2'b00;
    end

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_fault_nxt = r_fault;
        if (w_ctrl_wr && din[15])
            w_dir_nxt = r_dir & ~din[NB-1:0];
        case (r_state)
            ST_IDLE: if (w_start_ev) begin
                w_state_nxt = ST_RUN;
                w_dir_nxt   = '0;
                w_fault_nxt = 1'b0;
            end
            ST_RUN: if (w_stop_ev || w_abort || w_wdog_to) begin
                w_state_nxt = ST_STOP;
                w_dir_nxt   = '0;
                if (w_wdog_to)
                    w_fault_nxt = 1'b1;
            end else if (w_ctrl_wr && !din[15]) begin
                w_dir_nxt = w_set_dir;
            end
            ST_STOP: begin
                w_dir_nxt = '0;
                if (r_start_s2)
                    w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_dir_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_dir   <= '0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_dir   <= w_dir_nxt;
            r_fault <= w_fault_nxt;
        end
    end

    assign run     = (r_state == ST_RUN);
    assign move_en = {run, r_dir};

    // Bit 14 is the fault flag; with seven axes it shares the slot with the run bit.
    always_comb begin
        w_status       = '0;
        w_status[NB:0] = move_en;
        w_status[14]   = r_fault;
    end

    always_comb begin
        mem_dout = ram_dout;
        if (w_hit) begin
            mem_dout = '0;
            if (w_off == OFF_STATUS)
                mem_dout = w_status;
            for (int i = 0; i < NUM_AXES; i++)
                if (w_off == ADDR_W'(i))
                    mem_dout = axis_pos[i*DATA_W +: DATA_W];
        end
    end

endmodule

// File: tb/tb_mmio_motion_ctrl.sv
// Self-checking bench for mmio_motion_ctrl: behavioural model, directed scenarios, random traffic.
module tb_mmio_motion_ctrl;

    localparam int AW     = 15;
    localparam int DW     = 16;
    localparam int NA     = 3;
    localparam int BASE   = 20000;
    localparam int STAT_A = BASE + NA;
    localparam int CTRL_A = BASE + NA + 1;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           start_n = 1'b1;
    logic           times_up = 1'b0;
    logic           we = 1'b0;
    logic [AW-1:0]  addr = '0;
    logic [DW-1:0]  din = '0;
    logic [DW-1:0]  ram_dout = '0;
    logic [NA*DW-1:0] axis_pos = '0;
    logic [DW-1:0]  mem_dout;
    logic [2*NA:0]  move_en;
    logic           run;

    int n_checks = 0;
    int n_fail   = 0;

    typedef enum {M_IDLE, M_RUN, M_STOP} phase_t;
    phase_t        m_phase;
    int            m_dir [NA];      // -1 negative, 0 off, +1 positive
    logic          m_fault;
    logic [2:0]    m_sn_h, m_tu_h;  // [0] = sample at the latest edge
    logic [DW-1:0] m_pos [NA];

    int            press;
    logic          r_sn, r_tu, r_w;
    int            r_a;
    logic [15:0]   r_d;

    mmio_motion_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .start_n  (start_n),
        .times_up (times_up),
        .addr     (addr),
        .we       (we),
        .din      (din),
        .axis_pos (axis_pos),
        .ram_dout (ram_dout),
        .mem_dout (mem_dout),
        .move_en  (move_en),
        .run      (run)
    );

    always #5 clk = ~clk;

    initial begin
        #10000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2*NA:0] exp_move_en();
        logic [2*NA:0] v;
        v = '0;
        for (int i = 0; i < NA; i++) begin
            v[2*i]   = (m_dir[i] == -1);
            v[2*i+1] = (m_dir[i] == 1);
        end
        v[2*NA] = (m_phase == M_RUN);
        return v;
    endfunction

    function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
        int ai;
        logic [DW-1:0] s;
        ai = int'(a);
        if (ai >= BASE && ai < BASE + NA) return m_pos[ai-BASE];
        if (ai == STAT_A) begin
            s = '0;
            s[2*NA:0] = exp_move_en();
            s[14] = m_fault;
            return s;
        end
        if (ai == CTRL_A) return '0;
        return ram_dout;
    endfunction

    task automatic model_reset();
        m_phase = M_IDLE;
        for (int i = 0; i < NA; i++) m_dir[i] = 0;
        m_fault = 1'b0;
        m_sn_h  = 3'b111;
        m_tu_h  = 3'b000;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        logic sn_sync, sn_prev, tu_sync, start_ev, ctrl_wr, clr, abort;
        logic neg, pos;
        sn_sync  = m_sn_h[1];
        sn_prev  = m_sn_h[2];
        tu_sync  = m_tu_h[1];
        start_ev = sn_prev && !sn_sync;
        ctrl_wr  = we && (int'(addr) == CTRL_A);
        clr      = ctrl_wr && din[15];
        abort    = clr && din[14];
        if (clr)
            for (int i = 0; i < NA; i++) begin
                if (din[2*i]   && m_dir[i] == -1) m_dir[i] = 0;
                if (din[2*i+1] && m_dir[i] == 1)  m_dir[i] = 0;
            end
        case (m_phase)
            M_IDLE: if (start_ev) begin
                m_phase = M_RUN;
                for (int i = 0; i < NA; i++) m_dir[i] = 0;
                m_fault = 1'b0;
            end
            M_RUN: if (tu_sync || abort) begin
                m_phase = M_STOP;
                for (int i = 0; i < NA; i++) m_dir[i] = 0;
            end else if (ctrl_wr && !din[15]) begin
                for (int i = 0; i < NA; i++) begin
                    neg = (m_dir[i] == -1) || din[2*i];
                    pos = (m_dir[i] == 1)  || din[2*i+1];
                    if (neg && pos)  m_dir[i] = 0;
                    else if (neg)    m_dir[i] = -1;
                    else if (pos)    m_dir[i] = 1;
                    else             m_dir[i] = 0;
                end
            end
            default: begin
                for (int i = 0; i < NA; i++) m_dir[i] = 0;
                if (sn_sync) m_phase = M_IDLE;
            end
        endcase
        m_sn_h = {m_sn_h[1:0], start_n};
        m_tu_h = {m_tu_h[1:0], times_up};
    endtask

    task automatic pack_pos();
        for (int i = 0; i < NA; i++) axis_pos[i*DW +: DW] = m_pos[i];
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input logic sn, input logic tu, input logic w, input int a, input logic [15:0] d);
        start_n  = sn;
        times_up = tu;
        we       = w;
        addr     = AW'(a);
        din      = d;
        ram_dout = DW'($urandom);
        for (int i = 0; i < NA; i++) m_pos[i] = DW'($urandom);
        pack_pos();
        #1;
        check("mem_dout", 32'(mem_dout), 32'(exp_read(addr)));
        model_step();
        @(posedge clk);
        @(negedge clk);
        check("move_en", 32'(move_en), 32'(exp_move_en()));
        check("run", 32'(run), 32'(m_phase == M_RUN));
    endtask

    task automatic wr(input logic [15:0] d);
        step(1'b1, 1'b0, 1'b1, CTRL_A, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 0, 16'h0000);
    endtask

    task automatic peek(input int a, input logic [DW-1:0] exp, input string nm);
        we   = 1'b0;
        addr = AW'(a);
        #1;
        check(nm, 32'(mem_dout), 32'(exp));
        check({nm, "_model"}, 32'(exp_read(addr)), 32'(exp));
    endtask

    initial begin
        model_reset();
        for (int i = 0; i < NA; i++) m_pos[i] = '0;
        repeat (3) @(negedge clk);
        check("reset_move_en", 32'(move_en), 32'h0);
        check("reset_run", 32'(run), 32'h0);
        reset = 1'b1;

        idle(2);
        m_pos[1] = 16'h1234;
        pack_pos();
        peek(BASE + 1, 16'h1234, "axis1_read");
        ram_dout = 16'hA5C3;
        peek(BASE + 10, 16'hA5C3, "outside_read");

        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 0, 16'h0000);
        check("run_after_press", 32'(run), 32'h1);
        idle(2);

        wr(16'h0011);
        peek(STAT_A, 16'h0051, "status_set");
        wr(16'h8001);
        peek(STAT_A, 16'h0050, "status_clear");
        wr(16'h803F);
        wr(16'h0003);
        peek(STAT_A, 16'h0040, "both_bits_excl");
        wr(16'h0001);
        peek(STAT_A, 16'h0041, "neg_enabled");
        wr(16'h0002);
        peek(STAT_A, 16'h0040, "opposite_excl");
        wr(16'h0011);
        peek(STAT_A, 16'h0051, "status_before_reset");

        // Asynchronous reset in the middle of a run.
        #2;
        reset = 1'b0;
        #1;
        check("midrun_reset_move_en", 32'(move_en), 32'h0);
        check("midrun_reset_run", 32'(run), 32'h0);
        model_reset();
        ram_dout = 16'hBEEF;
        addr     = '0;
        #1;
        check("midrun_reset_ramread", 32'(mem_dout), 32'h0000BEEF);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 0, 16'h0000);
        check("run_after_restart", 32'(run), 32'h1);
        step(1'b0, 1'b1, 1'b0, 0, 16'h0000);
        step(1'b0, 1'b1, 1'b0, 0, 16'h0000);
        step(1'b0, 1'b1, 1'b1, CTRL_A, 16'h0004);
        check("stop_wins_move_en", 32'(move_en), 32'h0);
        check("stop_wins_run", 32'(run), 32'h0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 0, 16'h0000);
        check("held_in_stop", 32'(run), 32'h0);
        idle(3);
        wr(16'h0001);
        peek(STAT_A, 16'h0000, "set_ignored_idle");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 0, 16'h0000);
        check("run_from_idle", 32'(run), 32'h1);
        idle(2);

        press = 0;
        for (int c = 0; c < 3000; c++) begin
            if (press > 0) begin
                press--;
                r_sn = 1'b0;
            end else if ($urandom_range(0, 24) == 0) begin
                press = int'($urandom_range(0, 5));
                r_sn  = 1'b0;
            end else begin
                r_sn = 1'b1;
            end
            r_tu = ($urandom_range(0, 39) == 0);
            r_w  = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 7) == 0)      r_a = int'($urandom_range(0, 32767));
            else if ($urandom_range(0, 1) == 0) r_a = CTRL_A;
            else                                r_a = int'($urandom_range(BASE - 1, BASE + NA + 2));
            r_d     = 16'($urandom);
            r_d[15] = ($urandom_range(0, 2) == 0);
            r_d[14] = r_d[15] && ($urandom_range(0, 3) == 0);
            step(r_sn, r_tu, r_w, r_a, r_d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mmio_motion_ctrl.md
Name: mmio_motion_ctrl

Overview:
Parametrised memory-mapped motion-control register block on the CPU data bus, for NUM_AXES stepper axes. Overrides read data for its address window: axis position readback, status register, and a write-1-to-set / write-1-to-clear direction-enable register. A start-button/timer run state machine gates all motion. Sits between the CPU memory port and the block RAM read path; drives the per-axis motor enable lines.

Parameters:
ADDR_W, 15, CPU address width
DATA_W, 16, CPU data width
NUM_AXES, 3, axis count, 1..7 (2*NUM_AXES+1 <= 15)
BASE_ADDR, 20000, first address of the register window
WDOG_CYCLES, 50000000, watchdog timeout in clk cycles (used only with WATCHDOG_EN)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-low reset
start_n  input  1  start push-button, active-low, asynchronous to clk
times_up  input  1  run-timer expiry pulse/level, asynchronous to clk
addr  input  ADDR_W  CPU address
we  input  1  CPU write strobe
din  input  DATA_W  CPU write data
axis_pos  input  NUM_AXES*DATA_W  axis position counters, axis i at [i*DATA_W +: DATA_W]
ram_dout  input  DATA_W  block RAM read data
mem_dout  output  DATA_W  read data returned to CPU
move_en  output  2*NUM_AXES+1  bit 2i = axis i negative, bit 2i+1 = axis i positive, bit 2*NUM_AXES = run
run  output  1  run state active

Behaviour:
- Register map: BASE_ADDR+i (i<NUM_AXES) = axis_pos[i], read-only. BASE_ADDR+NUM_AXES = STATUS, read-only: [2N:0] = move_en, [14] = fault, other bits 0. BASE_ADDR+NUM_AXES+1 = CTRL, write-only, reads as 0.
- mem_dout is combinational: window register value when addr hits, otherwise ram_dout.
- start_n and times_up each pass through a 2-flop synchronizer. Start event = synchronized falling edge of start_n. Stop event = synchronized times_up high.
- FSM states: IDLE, RUN, STOP.
  - IDLE -> RUN on start event. Direction bits are cleared and fault is cleared.
  - RUN -> STOP on stop event, or on a CTRL write with din[15]=1 and din[14]=1 (abort).
  - STOP clears all direction bits the same cycle. STOP -> IDLE once start_n is synchronized high (button released).
- run = 1 only in RUN; move_en[2N] = run.
- CTRL write, registered, effective the cycle after we:
  - din[15]=0: set direction bits where din[2N-1:0]=1.
  - din[15]=1: clear direction bits where din[2N-1:0]=1.
  - Set writes are ignored outside RUN. Clear writes are honoured in any state.
  - If a set write sets both bits of an axis, or sets the opposite direction of an already-enabled axis, that axis's bits both become 0 (mutual exclusion). Other axes are unaffected.
- Simultaneous stop event and CTRL set write in RUN: stop wins, all direction bits become 0.
- Simultaneous start event while in STOP: ignored.
- Writes to non-CTRL window addresses are ignored. Addresses outside the window are not decoded.
- Reset, asynchronous whenever reset=0, including mid-run: state=IDLE, move_en=0, run=0, fault=0, synchronizers cleared to idle levels (start_n sync = 1, times_up sync = 0).

Optional Feature:
WATCHDOG_EN
- Defined: a counter runs in RUN and reloads on any CTRL write. At WDOG_CYCLES without a CTRL write: fault=1, RUN -> STOP. Fault is sticky until the next start event or reset.
- Undefined: no counter is instantiated; STATUS[14] is always 0.

Test Plan:
- Reset asserted mid-RUN with move_en=7'h51 -> move_en=0 and run=0 immediately; mem_dout=ram_dout at addr 0.
- NUM_AXES=3, addr=20001, axis_pos[1]=16'h1234 -> mem_dout=16'h1234. addr=20010 -> mem_dout=ram_dout.
- start_n low pulse -> run=1 within 3 cycles. CTRL write 16'h0011 -> STATUS reads 16'h0051. CTRL write 16'h8001 -> STATUS reads 16'h0050.
- In RUN, write 16'h0003 -> axis 0 bits stay 00. Enable bit 0, then write 16'h0002 -> axis 0 bits both 00.
- In RUN, times_up high in the same cycle as CTRL write 16'h0004 -> STOP, move_en=0. start_n held low stays in STOP; release -> IDLE.
- WATCHDOG_EN, WDOG_CYCLES=100, no writes in RUN -> at cycle 100 STATUS[14]=1, run=0. Next start clears fault.
